// File: rtl/rv_encode_pkg.sv
// Shared encoding constants for the RV32IM instruction encoder: opcodes,
// control-unit ALUOP codes, descriptor classes and encoder FSM states.
package rv_encode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [4:0] {
        ALU_NONE   = 5'd0,
        ALU_ADD    = 5'd1,
        ALU_SUB    = 5'd2,
        ALU_SLL    = 5'd3,
        ALU_SLT    = 5'd4,
        ALU_SLTU   = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SRL    = 5'd7,
        ALU_SRA    = 5'd8,
        ALU_OR     = 5'd9,
        ALU_AND    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } aluop_e;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I_ALU  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8
    } inst_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    typedef struct packed {
        logic       valid;
        logic       m_ext;
        logic [6:0] funct7;
        logic [2:0] funct3;
    } alu_fields_t;

    // M-extension codes are contiguous and map onto funct3 0..7 in order.
    function automatic alu_fields_t alu_fields(input logic [4:0] aluop);
        alu_fields_t f;
        f = '{valid: 1'b1, m_ext: 1'b0, funct7: 7'b0000000, funct3: 3'b000};
        case (aluop)
            ALU_ADD:  f.funct3 = 3'b000;
            ALU_SUB:  begin f.funct7 = 7'b0100000; f.funct3 = 3'b000; end
            ALU_SLL:  f.funct3 = 3'b001;
            ALU_SLT:  f.funct3 = 3'b010;
            ALU_SLTU: f.funct3 = 3'b011;
            ALU_XOR:  f.funct3 = 3'b100;
            ALU_SRL:  f.funct3 = 3'b101;
            ALU_SRA:  begin f.funct7 = 7'b0100000; f.funct3 = 3'b101; end
            ALU_OR:   f.funct3 = 3'b110;
            ALU_AND:  f.funct3 = 3'b111;
            default: begin
                if (aluop >= ALU_MUL && aluop <= ALU_REMU) begin
                    f.m_ext  = 1'b1;
                    f.funct7 = 7'b0000001;
                    f.funct3 = 3'(aluop - ALU_MUL);
                end else begin
                    f.valid = 1'b0;
                end
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Descriptor handshake and instruction-memory write bus of the encoder.
// slave is the encoder side, master is the producer/memory side.
interface instruction_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_class;
    logic [4:0]        in_aluop;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_write;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_busywait;

    modport slave (
        input  in_valid, in_class, in_aluop, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready,
        output imem_write, imem_addr, imem_wdata,
        input  imem_busywait
    );

    modport master (
        output in_valid, in_class, in_aluop, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready,
        input  imem_write, imem_addr, imem_wdata,
        output imem_busywait
    );
endinterface

// File: rtl/rv_inst_packer.sv
// Combinational packer: instruction descriptor -> RV32IM word plus an
// illegal flag for descriptors that have no valid encoding.
import rv_encode_pkg::*;

module rv_inst_packer (
    input  logic [3:0]  in_class,
    input  logic [4:0]  aluop,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    alu_fields_t af;
    logic        shift_op;

    assign af       = alu_fields(aluop);
    assign shift_op = (aluop == ALU_SLL) || (aluop == ALU_SRL) || (aluop == ALU_SRA);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (in_class)
            CLS_R: begin
                word    = {af.funct7, rs2, rs1, af.funct3, rd, OPC_OP};
                illegal = !af.valid;
            end
            CLS_I_ALU: begin
                if (shift_op)
                    word = {af.funct7, imm[4:0], rs1, af.funct3, rd, OPC_OP_IMM};
                else
                    word = {imm[11:0], rs1, af.funct3, rd, OPC_OP_IMM};
                illegal = !af.valid || af.m_ext || (aluop == ALU_SUB);
            end
            CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            CLS_LUI:    word = {imm[31:12], rd, OPC_LUI};
            CLS_AUIPC:  word = {imm[31:12], rd, OPC_AUIPC};
            default:    illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instruction_encoder.sv
// Program loader: packs descriptors into RV32IM words and writes them to
// consecutive instruction-memory words through a one-entry output buffer.
//
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start
//   ST_RUN   | accepting descriptors, writing words
//   ST_DRAIN | no more input, finishing the pending write
//   ST_DONE  | all words written, start begins a new run
import rv_encode_pkg::*;

module instruction_encoder #(
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  finish,
    input  logic [ADDR_W-1:0]     base_addr,
    instruction_encoder_if.slave  bus,
    output logic [ADDR_W-3:0]     word_count,
    output logic [ERR_W-1:0]      err_count,
    output logic                  done
);
    enc_state_e        state, state_nx;
    logic              full;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       packed_word;
    logic              packed_illegal;
    logic              complete;
    logic              accept;
    logic              start_run;

    rv_inst_packer u_packer (
        .in_class (bus.in_class),
        .aluop    (bus.in_aluop),
        .funct3   (bus.in_funct3),
        .rd       (bus.in_rd),
        .rs1      (bus.in_rs1),
        .rs2      (bus.in_rs2),
        .imm      (bus.in_imm),
        .word     (packed_word),
        .illegal  (packed_illegal)
    );

    assign complete  = full && !bus.imem_busywait;
    assign bus.in_ready = (state == ST_RUN) && (!full || complete);
    assign accept    = bus.in_valid && bus.in_ready;
    assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));

    assign bus.imem_write = full;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = out_word;
    assign done           = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)  state_nx = ST_RUN;
            ST_RUN:   if (finish) state_nx = ST_DRAIN;
            ST_DRAIN: if (!full || complete) state_nx = ST_DONE;
            ST_DONE:  if (start)  state_nx = ST_RUN;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // A completing write and a new accept on the same edge keep the buffer full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full       <= 1'b0;
            out_word   <= '0;
            addr       <= '0;
            word_count <= '0;
            err_count  <= '0;
        end else if (start_run) begin
            addr       <= base_addr & ~ADDR_W'(3);
            word_count <= '0;
            err_count  <= '0;
        end else begin
            if (complete) begin
                addr       <= addr + ADDR_W'(4);
                word_count <= word_count + (ADDR_W-2)'(1);
            end
            if (accept && packed_illegal) begin
                if (err_count != {ERR_W{1'b1}})
                    err_count <= err_count + ERR_W'(1);
            end else if (accept) begin
                out_word <= packed_word;
            end
            if (accept && !packed_illegal)
                full <= 1'b1;
            else if (complete)
                full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: table of descriptors with hand-encoded
// words, plus sequences for back-to-back, stall, drain, saturation, wrap and reset.
module tb_instruction_encoder;
    localparam int ADDR_W = 32;
    localparam int ERR_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-3:0] word_count;
    logic [ERR_W-1:0]  err_count;
    logic              done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr;
    logic [31:0] exp_wc;
    logic [31:0] exp_err;

    instruction_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_encoder #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .finish     (finish),
        .base_addr  (base_addr),
        .bus        (bus.slave),
        .word_count (word_count),
        .err_count  (err_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  aluop;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        ill;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [3:0] c, logic [4:0] a, logic [2:0] f3, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm,
                                logic [31:0] w, logic ill, string n);
        vec_t v;
        v.cls = c; v.aluop = a; v.f3 = f3; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.word = w; v.ill = ill; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input vec_t v);
        bus.in_class  = v.cls;
        bus.in_aluop  = v.aluop;
        bus.in_funct3 = v.f3;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_imm    = v.imm;
    endtask

    task automatic start_run(input logic [31:0] base);
        base_addr = base;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    vec_t v_add, v_addi, v_srai, v_sw, v_bad;

    initial begin
        bus.in_valid = 1'b0;
        bus.imem_busywait = 1'b0;
        v_add  = mk(4'd0, 5'd1,  3'd0, 5'd3, 5'd1, 5'd2, 32'd0,  32'h002081B3, 1'b0, "r_add");
        v_addi = mk(4'd1, 5'd1,  3'd0, 5'd1, 5'd0, 5'd0, 32'd5,  32'h00500093, 1'b0, "addi");
        v_srai = mk(4'd1, 5'd8,  3'd0, 5'd5, 5'd5, 5'd0, 32'd3,  32'h4032D293, 1'b0, "srai");
        v_sw   = mk(4'd3, 5'd0,  3'd2, 5'd0, 5'd1, 5'd2, 32'd8,  32'h0020A423, 1'b0, "sw");
        v_bad  = mk(4'd15, 5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0,  32'h0,        1'b1, "bad_class");
        set_desc(v_add);

        vq.push_back(v_add);
        vq.push_back(mk(4'd0, 5'd2,  3'd0, 5'd5,  5'd6,  5'd7,  32'd0,        32'h407302B3, 1'b0, "r_sub"));
        vq.push_back(mk(4'd0, 5'd11, 3'd0, 5'd1,  5'd2,  5'd3,  32'd0,        32'h023100B3, 1'b0, "r_mul"));
        vq.push_back(mk(4'd0, 5'd18, 3'd0, 5'd10, 5'd11, 5'd12, 32'd0,        32'h02C5F533, 1'b0, "r_remu"));
        vq.push_back(v_addi);
        vq.push_back(v_srai);
        vq.push_back(mk(4'd1, 5'd2,  3'd0, 5'd1,  5'd1,  5'd1,  32'd1,        32'h0,        1'b1, "i_sub_illegal"));
        vq.push_back(mk(4'd2, 5'd0,  3'd2, 5'd4,  5'd2,  5'd0,  32'hFFFFFFFF, 32'hFFF12203, 1'b0, "lw"));
        vq.push_back(v_sw);
        vq.push_back(mk(4'd4, 5'd0,  3'd0, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC, 32'hFE208EE3, 1'b0, "beq"));
        vq.push_back(mk(4'd5, 5'd0,  3'd0, 5'd1,  5'd0,  5'd0,  32'd8,        32'h008000EF, 1'b0, "jal"));
        vq.push_back(mk(4'd6, 5'd0,  3'd7, 5'd1,  5'd5,  5'd0,  32'd16,       32'h010280E7, 1'b0, "jalr"));
        vq.push_back(mk(4'd7, 5'd0,  3'd0, 5'd7,  5'd0,  5'd0,  32'h12345ABC, 32'h123453B7, 1'b0, "lui"));
        vq.push_back(mk(4'd8, 5'd0,  3'd0, 5'd2,  5'd0,  5'd0,  32'hFFFFF000, 32'hFFFFF117, 1'b0, "auipc"));
        vq.push_back(mk(4'd9, 5'd0,  3'd0, 5'd1,  5'd1,  5'd1,  32'd0,        32'h0,        1'b1, "class9"));
        vq.push_back(mk(4'd0, 5'd0,  3'd0, 5'd1,  5'd1,  5'd1,  32'd0,        32'h0,        1'b1, "r_aluop0"));
        vq.push_back(mk(4'd0, 5'd19, 3'd0, 5'd1,  5'd1,  5'd1,  32'd0,        32'h0,        1'b1, "r_aluop19"));
        vq.push_back(mk(4'd1, 5'd11, 3'd0, 5'd1,  5'd1,  5'd1,  32'd0,        32'h0,        1'b1, "i_mul_illegal"));
        vq.push_back(mk(4'd1, 5'd10, 3'd0, 5'd3,  5'd4,  5'd0,  32'h00001234, 32'h23427193, 1'b0, "andi_trunc"));
        vq.push_back(mk(4'd1, 5'd3,  3'd0, 5'd1,  5'd2,  5'd0,  32'h00000025, 32'h00511093, 1'b0, "slli"));

        // Reset state
        #12 rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_imem_write", {31'd0, bus.imem_write}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_word_count", {2'b0, word_count}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);

        step();
        start_run(32'h0000_0100);
        exp_addr = 32'h100; exp_wc = 0; exp_err = 0;
        check("start_addr", bus.imem_addr, exp_addr);

        // Table: one descriptor at a time, latency-1 write, no stall
        for (int i = 0; i < vq.size(); i++) begin
            set_desc(vq[i]);
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            if (!vq[i].ill) begin
                check({vq[i].name, "_write"}, {31'd0, bus.imem_write}, 32'd1);
                check({vq[i].name, "_addr"}, bus.imem_addr, exp_addr);
                check({vq[i].name, "_wdata"}, bus.imem_wdata, vq[i].word);
                step();
                exp_addr += 4;
                exp_wc++;
                check({vq[i].name, "_wc"}, {2'b0, word_count}, exp_wc);
                check({vq[i].name, "_idle_write"}, {31'd0, bus.imem_write}, 32'd0);
            end else begin
                exp_err++;
                check({vq[i].name, "_nowrite"}, {31'd0, bus.imem_write}, 32'd0);
                check({vq[i].name, "_err"}, {24'd0, err_count}, exp_err);
                check({vq[i].name, "_addr_kept"}, bus.imem_addr, exp_addr);
            end
        end

        // Back-to-back ADDI, SRAI
        set_desc(v_addi);
        bus.in_valid = 1'b1;
        step();
        check("b2b_w1", {31'd0, bus.imem_write}, 32'd1);
        check("b2b_a1", bus.imem_addr, exp_addr);
        check("b2b_d1", bus.imem_wdata, 32'h00500093);
        set_desc(v_srai);
        #1 check("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        exp_addr += 4; exp_wc++;
        check("b2b_w2", {31'd0, bus.imem_write}, 32'd1);
        check("b2b_a2", bus.imem_addr, exp_addr);
        check("b2b_d2", bus.imem_wdata, 32'h4032D293);
        step();
        exp_addr += 4; exp_wc++;
        check("b2b_end_write", {31'd0, bus.imem_write}, 32'd0);
        check("b2b_wc", {2'b0, word_count}, exp_wc);

        // Store held for three stalled cycles, second descriptor blocked
        set_desc(v_sw);
        bus.in_valid = 1'b1;
        bus.imem_busywait = 1'b1;
        step();
        check("stall_write", {31'd0, bus.imem_write}, 32'd1);
        check("stall_addr0", bus.imem_addr, exp_addr);
        check("stall_data0", bus.imem_wdata, 32'h0020A423);
        set_desc(v_add);
        #1 check("stall_ready0", {31'd0, bus.in_ready}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_addr", bus.imem_addr, exp_addr);
            check("stall_data", bus.imem_wdata, 32'h0020A423);
            check("stall_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_wc", {2'b0, word_count}, exp_wc);
        end
        bus.imem_busywait = 1'b0;
        #1 check("stall_release_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        exp_addr += 4; exp_wc++;
        check("stall_done_wc", {2'b0, word_count}, exp_wc);
        check("stall_next_addr", bus.imem_addr, exp_addr);
        check("stall_next_data", bus.imem_wdata, 32'h002081B3);
        check("stall_next_write", {31'd0, bus.imem_write}, 32'd1);
        bus.in_valid = 1'b0;
        step();
        exp_addr += 4; exp_wc++;
        check("stall_final_wc", {2'b0, word_count}, exp_wc);

        // START ignored while running
        start_run(32'h0000_0800);
        check("start_in_run_addr", bus.imem_addr, exp_addr);
        check("start_in_run_wc", {2'b0, word_count}, exp_wc);
        check("start_in_run_ready", {31'd0, bus.in_ready}, 32'd1);

        // FINISH with a pending stalled word
        set_desc(v_addi);
        bus.in_valid = 1'b1;
        bus.imem_busywait = 1'b1;
        step();
        bus.in_valid = 1'b0;
        finish = 1'b1;
        step();
        finish = 1'b0;
        check("drain_done0", {31'd0, done}, 32'd0);
        check("drain_write", {31'd0, bus.imem_write}, 32'd1);
        bus.in_valid = 1'b1;
        #1 check("drain_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        step();
        check("drain_done1", {31'd0, done}, 32'd0);
        bus.imem_busywait = 1'b0;
        step();
        exp_addr += 4; exp_wc++;
        check("drain_done2", {31'd0, done}, 32'd1);
        check("drain_write_end", {31'd0, bus.imem_write}, 32'd0);
        check("drain_wc", {2'b0, word_count}, exp_wc);

        // Error counter saturation
        start_run(32'h0);
        check("sat_start_err", {24'd0, err_count}, 32'd0);
        check("sat_start_wc", {2'b0, word_count}, 32'd0);
        set_desc(v_bad);
        bus.in_valid = 1'b1;
        repeat (260) step();
        bus.in_valid = 1'b0;
        check("sat_err", {24'd0, err_count}, 32'd255);
        check("sat_wc", {2'b0, word_count}, 32'd0);
        check("sat_write", {31'd0, bus.imem_write}, 32'd0);
        finish = 1'b1;
        step();
        finish = 1'b0;
        step();
        check("sat_done", {31'd0, done}, 32'd1);

        // Address wrap, base low bits forced to zero
        start_run(32'hFFFF_FFFF);
        check("wrap_base", bus.imem_addr, 32'hFFFF_FFFC);
        check("wrap_err_clear", {24'd0, err_count}, 32'd0);
        set_desc(v_addi);
        bus.in_valid = 1'b1;
        step();
        check("wrap_a0", bus.imem_addr, 32'hFFFF_FFFC);
        set_desc(v_srai);
        step();
        bus.in_valid = 1'b0;
        check("wrap_a1", bus.imem_addr, 32'h0000_0000);
        check("wrap_d1", bus.imem_wdata, 32'h4032D293);
        step();
        check("wrap_wc", {2'b0, word_count}, 32'd2);

        // Reset in the middle of a stalled write
        set_desc(v_add);
        bus.in_valid = 1'b1;
        bus.imem_busywait = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("prerst_write", {31'd0, bus.imem_write}, 32'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_write", {31'd0, bus.imem_write}, 32'd0);
        check("rst_mid_wc", {2'b0, word_count}, 32'd0);
        check("rst_mid_addr", bus.imem_addr, 32'd0);
        check("rst_mid_wdata", bus.imem_wdata, 32'd0);
        #2 rst_n = 1'b1;
        step();
        bus.in_valid = 1'b1;
        bus.imem_busywait = 1'b0;
        #1 check("rst_idle_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("rst_idle_write", {31'd0, bus.imem_write}, 32'd0);
        check("rst_idle_done", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
